control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter WORD_SIZE, 16, sets the instruction, counter and datapath word width.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 Reset_N  input  1  asynchronous, active-low reset.
REQ-004 instruction  input  WORD_SIZE  instruction memory read data; valid when i_ready=1.
REQ-005 i_ready  input  1  instruction memory acknowledge for the current i_read request.
REQ-006 d_ready  input  1  data memory acknowledge for the current d_read or d_write request.
REQ-007 Bcond  input  1  branch-taken flag returned by the ALU, sampled in EX.
REQ-008 i_read  output  1  instruction fetch request.
REQ-009 d_read, d_write  output  1 each  data memory load and store requests.
REQ-010 alu_opcode  output  4  ALU opcode; equals IR[15:12].
REQ-011 alu_func  output  6  ALU function code; equals IR[5:0].
REQ-012 alu_src_imm  output  1  selects the sign-extended IR[7:0] as the second ALU operand; 0 selects register rt.
REQ-013 reg_write  output  1  register file write enable.
REQ-014 pc_write  output  1  PC load enable.
REQ-015 pc_src  output  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target {PC[15:12],IR[11:0]}, 3 = register rs.
REQ-016 link  output  1  selects PC+1 as register write data and $2 as the destination register.
REQ-017 num_inst  output  WORD_SIZE  count of completed instructions.
REQ-018 is_halted  output  1  high while in the HALT state.

Function
REQ-019 The block SHALL implement the states IF, ID, EX, MEM, WB and HALT, encoded in 3 bits.
REQ-020 In IF, the block SHALL hold i_read=1 until i_ready=1, then latch instruction into IR and move to ID; while i_ready=0 it SHALL remain in IF.
REQ-021 i_ready and d_ready SHALL be ignored in every state other than the one that issued the matching request.
REQ-022 ID with opcode 15 and func 29 (HLT) SHALL move to HALT and count the instruction.
REQ-023 ID with func 28 (WWD) SHALL move to IF with pc_write=1 and pc_src=0.
REQ-024 ID with opcode 9 (JMP) or func 25 (JPR) SHALL move to IF with pc_write=1 and pc_src=2 or 3 respectively.
REQ-025 ID with opcode 10 (JAL) or func 26 (JRL) SHALL move to WB with link=1, then apply pc_src=2 or 3 respectively in WB.
REQ-026 ID with any other opcode SHALL move to EX.
REQ-027 In EX, alu_src_imm SHALL be 1 for opcodes 4 through 8 (ADI, ORI, LHI, LWD, SWD) and 0 otherwise.
REQ-028 In EX, opcodes 0 through 3 (branches) SHALL assert pc_write=1, with pc_src=1 if Bcond=1 and pc_src=0 otherwise, then move to IF.
REQ-029 In EX, LWD and SWD SHALL move to MEM; all other opcodes SHALL move to WB.
REQ-030 In MEM, the block SHALL hold d_read=1 (LWD) or d_write=1 (SWD) until d_ready=1; LWD then moves to WB and SWD moves to IF with pc_write=1 and pc_src=0.
REQ-031 In WB, reg_write SHALL be 1 for exactly one cycle; non-jump instructions SHALL also assert pc_write=1 with pc_src=0; WB then moves to IF.
REQ-032 pc_write, reg_write, d_read, d_write and i_read SHALL each be high for at most one state visit per instruction, and d_read and d_write SHALL never be high together.
REQ-033 num_inst SHALL increment by 1 on every transition into IF or HALT that completes an instruction, and SHALL wrap from 16'hFFFF to 0.
REQ-034 Minimum latencies with zero-wait memory SHALL be: R-type 4 cycles, branch 3, LWD 5, SWD 4, JMP 2, JAL 3.
REQ-035 HALT SHALL be left only by reset, with all request and enable outputs held at 0.

Reset
REQ-036 Reset_N=0 SHALL immediately force state=IF, IR=0 and num_inst=0, and drive every output to 0 except i_read, which is driven combinationally from state.
REQ-037 Reset asserted mid-instruction SHALL abort the instruction with no further pc_write or reg_write, and with no increment of num_inst.
REQ-038 After Reset_N deasserts, the first fetch SHALL begin on the next rising edge of clk.

Verification
REQ-039 The bench SHALL cover: ADD (16'hF000) with zero-wait memory -> states IF, ID, EX, WB; reg_write high in the 4th cycle; num_inst=1.
REQ-040 The bench SHALL cover: BEQ with Bcond=1, then Bcond=0 -> pc_src=1 and then pc_src=0; pc_write high in EX; no reg_write.
REQ-041 The bench SHALL cover: LWD with d_ready held low for 3 cycles -> d_read high for 4 cycles, then WB with reg_write=1.
REQ-042 The bench SHALL cover: JAL 16'hA123 -> WB with link=1, pc_src=2 and reg_write=1; 3 cycles total.
REQ-043 The bench SHALL cover: HLT -> is_halted=1 with no outputs for 10 further cycles; Reset_N pulse -> IF and num_inst=0.
REQ-044 The bench SHALL cover: Reset_N dropped mid-MEM, asynchronous to clk -> d_read falls without waiting for an edge and num_inst is unchanged (0).

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences IF/ID/EX/MEM/WB per instruction, decodes
// control strobes from the latched instruction and counts completed instructions.
module control_fsm #(
   parameter int unsigned WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 Reset_N,
   input  logic [WORD_SIZE-1:0] instruction,
   input  logic                 i_ready,
   input  logic                 d_ready,
   input  logic                 Bcond,
   output logic                 i_read,
   output logic                 d_read,
   output logic                 d_write,
   output logic [3:0]           alu_opcode,
   output logic [5:0]           alu_func,
   output logic                 alu_src_imm,
   output logic                 reg_write,
   output logic                 pc_write,
   output logic [1:0]           pc_src,
   output logic                 link,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 is_halted
);

   localparam int unsigned IR_W = 16;

   localparam logic [3:0] OP_LAST_BR = 4'd3;
   localparam logic [3:0] OP_ADI     = 4'd4;
   localparam logic [3:0] OP_LWD     = 4'd7;
   localparam logic [3:0] OP_SWD     = 4'd8;
   localparam logic [3:0] OP_JMP     = 4'd9;
   localparam logic [3:0] OP_JAL     = 4'd10;
   localparam logic [3:0] OP_RTYPE   = 4'd15;

   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   localparam logic [1:0] PC_NEXT = 2'd0;
   localparam logic [1:0] PC_BR   = 2'd1;
   localparam logic [1:0] PC_JMP  = 2'd2;
   localparam logic [1:0] PC_REG  = 2'd3;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t           state, next_state;
   logic [IR_W-1:0]  ir;
   logic [3:0]       op;
   logic [5:0]       fn;
   logic             is_r, is_jal, is_jrl;
   logic             done_c;
   logic             unused_ir_c;

   assign op         = ir[15:12];
   assign fn         = ir[5:0];
   assign is_r       = (op == OP_RTYPE);
   assign is_jal     = (op == OP_JAL);
   assign is_jrl     = is_r && (fn == FN_JRL);
   assign alu_opcode = op;
   assign alu_func   = fn;
   assign is_halted  = (state == S_HALT);
   assign unused_ir_c = ^ir[11:6];

   // State, instruction register and retired-instruction counter
   always_ff @(posedge clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state    <= S_IF;
         ir       <= '0;
         num_inst <= '0;
      end else begin
         state <= next_state;
         if (state == S_IF && i_ready) begin
            ir <= instruction[IR_W-1:0];
         end
         if (done_c) begin
            num_inst <= num_inst + WORD_SIZE'(1);
         end
      end
   end

   // Next-state and control strobe decode
   always_comb begin
      next_state  = state;
      i_read      = 1'b0;
      d_read      = 1'b0;
      d_write     = 1'b0;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_NEXT;
      link        = 1'b0;
      done_c      = 1'b0;
      case (state)
         S_IF: begin
            i_read = 1'b1;
            if (i_ready) next_state = S_ID;
         end
         S_ID: begin
            if (is_r && fn == FN_HLT) begin
               next_state = S_HALT;
               done_c     = 1'b1;
            end else if (is_r && fn == FN_WWD) begin
               pc_write   = 1'b1;
               pc_src     = PC_NEXT;
               next_state = S_IF;
               done_c     = 1'b1;
            end else if (op == OP_JMP) begin
               pc_write   = 1'b1;
               pc_src     = PC_JMP;
               next_state = S_IF;
               done_c     = 1'b1;
            end else if (is_r && fn == FN_JPR) begin
               pc_write   = 1'b1;
               pc_src     = PC_REG;
               next_state = S_IF;
               done_c     = 1'b1;
            end else if (is_jal || is_jrl) begin
               next_state = S_WB;
            end else begin
               next_state = S_EX;
            end
         end
         S_EX: begin
            alu_src_imm = (op >= OP_ADI) && (op <= OP_SWD);
            if (op <= OP_LAST_BR) begin
               pc_write   = 1'b1;
               pc_src     = Bcond ? PC_BR : PC_NEXT;
               next_state = S_IF;
               done_c     = 1'b1;
            end else if (op == OP_LWD || op == OP_SWD) begin
               next_state = S_MEM;
            end else begin
               next_state = S_WB;
            end
         end
         S_MEM: begin
            d_read  = (op == OP_LWD);
            d_write = (op == OP_SWD);
            if (d_ready) begin
               if (op == OP_SWD) begin
                  pc_write   = 1'b1;
                  pc_src     = PC_NEXT;
                  next_state = S_IF;
                  done_c     = 1'b1;
               end else begin
                  next_state = S_WB;
               end
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            link       = is_jal || is_jrl;
            pc_src     = is_jal ? PC_JMP : (is_jrl ? PC_REG : PC_NEXT);
            next_state = S_IF;
            done_c     = 1'b1;
         end
         S_HALT: begin
            next_state = S_HALT;
         end
         default: begin
            next_state = S_IF;
         end
      endcase
   end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle strobe vectors and instruction
// counts for each instruction class, halt, and asynchronous reset.
module tb_control_fsm;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         Reset_N;
   logic [W-1:0] instruction;
   logic         i_ready, d_ready, Bcond;
   logic         i_read, d_read, d_write, alu_src_imm, reg_write, pc_write, link, is_halted;
   logic [3:0]   alu_opcode;
   logic [5:0]   alu_func;
   logic [1:0]   pc_src;
   logic [W-1:0] num_inst;
   logic [9:0]   outs;

   int           n_cmp = 0;
   int           n_mis = 0;
   logic [W-1:0] exp_n;

   control_fsm #(.WORD_SIZE(W)) dut (
      .clk(clk), .Reset_N(Reset_N), .instruction(instruction),
      .i_ready(i_ready), .d_ready(d_ready), .Bcond(Bcond),
      .i_read(i_read), .d_read(d_read), .d_write(d_write),
      .alu_opcode(alu_opcode), .alu_func(alu_func), .alu_src_imm(alu_src_imm),
      .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src), .link(link),
      .num_inst(num_inst), .is_halted(is_halted)
   );

   always #5 clk = ~clk;

   assign outs = {i_read, d_read, d_write, alu_src_imm, reg_write, pc_write, pc_src, link, is_halted};

   // Expected strobe vector in the same bit order as outs
   function automatic logic [9:0] ev(input logic ir, input logic dr, input logic dw,
                                     input logic imm, input logic rw, input logic pw,
                                     input logic [1:0] src, input logic lk, input logic h);
      return {ir, dr, dw, imm, rw, pw, src, lk, h};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Check the strobes of the current state, then advance one clock
   task automatic cyc(input string tag, input logic [9:0] exp);
      @(negedge clk);
      chk(tag, 32'(outs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   // Drive noise on the memory handshakes while they must be ignored
   task automatic park();
      instruction = 16'h6E6E;
      i_ready     = 1'b1;
      d_ready     = 1'b1;
      Bcond       = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] instr, input int waits);
      i_ready     = 1'b0;
      instruction = ~instr;
      for (int k = 0; k < waits; k++) cyc("if_wait", ev(1,0,0,0,0,0,2'd0,0,0));
      instruction = instr;
      i_ready     = 1'b1;
      cyc("if", ev(1,0,0,0,0,0,2'd0,0,0));
      park();
   endtask

   task automatic retired(input string tag);
      exp_n = exp_n + W'(1);
      chk(tag, 32'(num_inst), 32'(exp_n));
   endtask

   initial begin
      Reset_N     = 1'b0;
      instruction = 16'hF0FF;
      i_ready     = 1'b1;
      d_ready     = 1'b1;
      Bcond       = 1'b1;
      exp_n       = '0;
      #2;
      chk("rst_outs", 32'(outs), 32'(ev(1,0,0,0,0,0,2'd0,0,0)));
      chk("rst_num", 32'(num_inst), 32'd0);
      chk("rst_op", 32'(alu_opcode), 32'd0);
      chk("rst_func", 32'(alu_func), 32'd0);
      @(posedge clk);
      #3;
      chk("rst_hold_op", 32'(alu_opcode), 32'd0);
      Reset_N = 1'b1;

      // ADD: IF ID EX WB, reg_write in the 4th cycle
      fetch(16'hF000, 0);
      cyc("add_id", ev(0,0,0,0,0,0,2'd0,0,0));
      chk("add_op", 32'(alu_opcode), 32'hF);
      cyc("add_ex", ev(0,0,0,0,0,0,2'd0,0,0));
      chk("add_wb_op", 32'(alu_opcode), 32'hF);
      cyc("add_wb", ev(0,0,0,0,1,1,2'd0,0,0));
      retired("add_num");

      // BEQ taken then not taken
      fetch(16'h0105, 0);
      cyc("beq_t_id", ev(0,0,0,0,0,0,2'd0,0,0));
      Bcond = 1'b1;
      cyc("beq_t_ex", ev(0,0,0,0,0,1,2'd1,0,0));
      retired("beq_t_num");
      fetch(16'h0105, 1);
      Bcond = 1'b1;
      cyc("beq_n_id", ev(0,0,0,0,0,0,2'd0,0,0));
      Bcond = 1'b0;
      cyc("beq_n_ex", ev(0,0,0,0,0,1,2'd0,0,0));
      retired("beq_n_num");

      // ADI: immediate operand, write back
      fetch(16'h4105, 0);
      cyc("adi_id", ev(0,0,0,0,0,0,2'd0,0,0));
      cyc("adi_ex", ev(0,0,0,1,0,0,2'd0,0,0));
      cyc("adi_wb", ev(0,0,0,0,1,1,2'd0,0,0));
      retired("adi_num");

      // LWD with three data wait states
      fetch(16'h7203, 0);
      cyc("lwd_id", ev(0,0,0,0,0,0,2'd0,0,0));
      cyc("lwd_ex", ev(0,0,0,1,0,0,2'd0,0,0));
      d_ready = 1'b0;
      for (int k = 0; k < 3; k++) cyc("lwd_mem_wait", ev(0,1,0,0,0,0,2'd0,0,0));
      d_ready = 1'b1;
      cyc("lwd_mem", ev(0,1,0,0,0,0,2'd0,0,0));
      cyc("lwd_wb", ev(0,0,0,0,1,1,2'd0,0,0));
      retired("lwd_num");

      // SWD, zero-wait store finishes in MEM
      fetch(16'h8203, 0);
      cyc("swd_id", ev(0,0,0,0,0,0,2'd0,0,0));
      cyc("swd_ex", ev(0,0,0,1,0,0,2'd0,0,0));
      cyc("swd_mem", ev(0,0,1,0,0,1,2'd0,0,0));
      retired("swd_num");

      // Jumps and WWD
      fetch(16'h9123, 0);
      cyc("jmp_id", ev(0,0,0,0,0,1,2'd2,0,0));
      retired("jmp_num");
      fetch(16'hA123, 0);
      cyc("jal_id", ev(0,0,0,0,0,0,2'd0,0,0));
      cyc("jal_wb", ev(0,0,0,0,1,1,2'd2,1,0));
      retired("jal_num");
      fetch(16'hF019, 0);
      cyc("jpr_id", ev(0,0,0,0,0,1,2'd3,0,0));
      retired("jpr_num");
      fetch(16'hF01A, 0);
      cyc("jrl_id", ev(0,0,0,0,0,0,2'd0,0,0));
      cyc("jrl_wb", ev(0,0,0,0,1,1,2'd3,1,0));
      retired("jrl_num");
      fetch(16'hF01C, 0);
      cyc("wwd_id", ev(0,0,0,0,0,1,2'd0,0,0));
      retired("wwd_num");

      // HLT after a slow fetch, then stays halted
      fetch(16'hF01D, 2);
      cyc("hlt_id", ev(0,0,0,0,0,0,2'd0,0,0));
      retired("hlt_num");
      for (int k = 0; k < 10; k++) begin
         i_ready = k[0];
         d_ready = ~k[0];
         cyc("halt", ev(0,0,0,0,0,0,2'd0,0,1));
      end
      chk("halt_num", 32'(num_inst), 32'(exp_n));

      // Reset pulse leaves HALT
      #1;
      Reset_N = 1'b0;
      i_ready = 1'b0;
      #1;
      chk("halt_rst_outs", 32'(outs), 32'(ev(1,0,0,0,0,0,2'd0,0,0)));
      chk("halt_rst_num", 32'(num_inst), 32'd0);
      exp_n = '0;
      @(negedge clk);
      Reset_N = 1'b1;
      @(posedge clk);
      #1;

      // Reset dropped between edges while LWD waits in MEM
      fetch(16'h7203, 0);
      cyc("abort_id", ev(0,0,0,0,0,0,2'd0,0,0));
      cyc("abort_ex", ev(0,0,0,1,0,0,2'd0,0,0));
      d_ready = 1'b0;
      @(negedge clk);
      chk("abort_mem_dread", 32'(d_read), 32'd1);
      #2;
      Reset_N = 1'b0;
      #1;
      chk("abort_outs", 32'(outs), 32'(ev(1,0,0,0,0,0,2'd0,0,0)));
      chk("abort_num", 32'(num_inst), 32'(exp_n));
      @(posedge clk);
      #1;
      chk("abort_num_edge", 32'(num_inst), 32'd0);
      chk("abort_outs_edge", 32'(outs), 32'(ev(1,0,0,0,0,0,2'd0,0,0)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
